srv_core_system: RTL and testbench

- Top of a minimal RV32I processing system: one in-order, multi-cycle RV32I core, a 64-bit-wide instruction TCM (ITCM) and a 64-bit-wide data TCM (DTCM).
- No external bus; software runs entirely from the TCMs.
- Benches preload the TCMs and inspect them by backdoor access to the instance/array names below.
- Programs signal completion by storing 1 to DTCM offset 0x960.

---
 rtl/srv_core_system_if.sv | 23 ++
 rtl/srv_core_system.sv | 257 +++++++++++++++++++++++++
 tb/tb_srv_core_system.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/srv_core_system_if.sv
// Tightly-coupled memory port shared by the instruction and data sides.
//
// Handshake: re (read) and be (per-byte write enables) are request strobes
// that are valid only in the cycle they are driven. The memory is always
// ready, so there is no ready signal. Read data appears on rdata exactly
// one cycle after a cycle with re=1. A cycle with re=0 returns zero.
//
// Signals:
//   addr   32-bit byte address (master -> slave)
//   re     read request strobe (master -> slave)
//   be     8 byte-lane write enables for the addressed 64-bit word
//   wdata  64-bit write data, lane-aligned
//   rdata  64-bit registered read data (slave -> master)
interface srv_core_system_if;
  logic [31:0] addr;
  logic        re;
  logic [7:0]  be;
  logic [63:0] wdata;
  logic [63:0] rdata;

  modport master (output addr, re, be, wdata, input rdata);
  modport slave  (input addr, re, be, wdata, output rdata);
endinterface

// File: rtl/srv_core_system.sv
// Minimal RV32I system: a multi-cycle in-order core (u_core), a 64-bit
// instruction TCM at 0x8000_0000 (u_itcm) and a 64-bit data TCM at
// 0x9000_0000 (u_dtcm). Software runs entirely from the TCMs.
//
// Top ports:
//   clk       clock, all state updates on the rising edge
//   reset     synchronous active-high reset
//   reset_pc  PC loaded while reset is high

// Single-port TCM: 2**AW words of 64 bits, byte-lane writes, registered read.
module srv_tcm #(
  parameter int          AW     = 12,
  parameter logic [3:0]  REGION = 4'h8
) (
  input logic                clk,
  srv_core_system_if.slave   bus
);
  logic [63:0]   mem [0:2**AW-1];
  logic [63:0]   rdata_q;
  logic [AW-1:0] idx;
  logic          hit;

  // Upper offset bits are ignored, so accesses alias within the region.
  assign idx = bus.addr[AW+2:3];
  assign hit = (bus.addr[31:28] == REGION);
  wire unused_addr = &{1'b0, bus.addr};

  always_ff @(posedge clk) begin
    if (hit) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.be[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
    // Out-of-region reads return zero (a NOP when fetched).
    rdata_q <= (hit && bus.re) ? mem[idx] : 64'd0;
  end

  assign bus.rdata = rdata_q;
endmodule

// Multi-cycle RV32I core: FETCH -> EXEC (-> LOAD) -> FETCH.
module srv_core (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        reset_pc_i,
  srv_core_system_if.master  ibus,
  srv_core_system_if.master  dbus
);
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011, OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011, OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [0:31];
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [2:0]  ld_off_q, ld_off_d;

  logic [31:0] instr, rs1v, rs2v, pc4;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] ld_addr, st_addr, ld_word;
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        wb_en, br_taken, op_legal, opimm_legal;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  function automatic logic [31:0] alu(input logic [2:0] fn, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    case (fn)
      3'd0:    alu = alt ? a - b : a + b;
      3'd1:    alu = a << b[4:0];
      3'd2:    alu = {31'd0, $signed(a) < $signed(b)};
      3'd3:    alu = {31'd0, a < b};
      3'd4:    alu = a ^ b;
      3'd5:    alu = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  // The fetched 64-bit word holds two instructions; pc[2] picks one.
  assign instr  = pc_q[2] ? ibus.rdata[63:32] : ibus.rdata[31:0];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];
  assign rs1v   = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2v   = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
  assign pc4    = pc_q + 32'd4;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign ld_addr = rs1v + imm_i;
  assign st_addr = rs1v + imm_s;

  // Only SUB/SRA use funct7=0x20; any other funct7 is illegal and a NOP.
  assign op_legal    = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
  assign opimm_legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                       (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;

  always_comb begin
    case (f3)
      3'd0:    br_taken = (rs1v == rs2v);
      3'd1:    br_taken = (rs1v != rs2v);
      3'd4:    br_taken = ($signed(rs1v) <  $signed(rs2v));
      3'd5:    br_taken = ($signed(rs1v) >= $signed(rs2v));
      3'd6:    br_taken = (rs1v <  rs2v);
      3'd7:    br_taken = (rs1v >= rs2v);
      default: br_taken = 1'b0;
    endcase
  end

  // Load data extraction from the word returned one cycle after EXEC.
  assign ld_word = ld_off_q[2] ? dbus.rdata[63:32] : dbus.rdata[31:0];
  assign ld_byte = ld_word[{ld_off_q[1:0], 3'b000} +: 8];
  assign ld_half = ld_off_q[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ld_rd_d    = ld_rd_q;
    ld_f3_d    = ld_f3_q;
    ld_off_d   = ld_off_q;
    wb_en      = 1'b0;
    wb_rd      = rd;
    wb_data    = 32'd0;
    ibus.addr  = pc_q;
    ibus.re    = 1'b0;
    ibus.be    = 8'd0;
    ibus.wdata = 64'd0;
    dbus.addr  = 32'd0;
    dbus.re    = 1'b0;
    dbus.be    = 8'd0;
    dbus.wdata = 64'd0;
    case (state_q)
      ST_FETCH: begin
        ibus.re = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc4;
        case (opcode)
          OP_LUI:   begin wb_en = 1'b1; wb_data = imm_u; end
          OP_AUIPC: begin wb_en = 1'b1; wb_data = pc_q + imm_u; end
          OP_JAL:   begin wb_en = 1'b1; wb_data = pc4; pc_d = pc_q + imm_j; end
          OP_JALR: if (f3 == 3'd0) begin
            wb_en = 1'b1; wb_data = pc4; pc_d = ld_addr & ~32'd1;
          end
          OP_BR: if (br_taken) pc_d = pc_q + imm_b;
          OP_LOAD: if (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) begin
            dbus.re   = 1'b1;
            dbus.addr = ld_addr;
            ld_rd_d   = rd;
            ld_f3_d   = f3;
            ld_off_d  = ld_addr[2:0];
            pc_d      = pc_q;
            state_d   = ST_LOAD;
          end
          OP_ST: begin
            dbus.addr = st_addr;
            // Reset in this cycle aborts the store.
            if (!reset) begin
              case (f3)
                3'd0: begin dbus.be = 8'b1 << st_addr[2:0];
                            dbus.wdata = {8{rs2v[7:0]}}; end
                3'd1: begin dbus.be = 8'b11 << {st_addr[2:1], 1'b0};
                            dbus.wdata = {4{rs2v[15:0]}}; end
                3'd2: begin dbus.be = 8'hF << {st_addr[2], 2'b00};
                            dbus.wdata = {2{rs2v}}; end
                default: dbus.be = 8'd0;
              endcase
            end
          end
          OP_IMM: if (opimm_legal) begin
            wb_en = 1'b1; wb_data = alu(f3, (f3 == 3'd5) && f7[5], rs1v, imm_i);
          end
          OP_REG: if (op_legal) begin
            wb_en = 1'b1; wb_data = alu(f3, f7[5], rs1v, rs2v);
          end
          default: wb_en = 1'b0;
        endcase
      end
      ST_LOAD: begin
        wb_en   = 1'b1;
        wb_rd   = ld_rd_q;
        pc_d    = pc4;
        state_d = ST_FETCH;
        case (ld_f3_q)
          3'd0:    wb_data = {{24{ld_byte[7]}}, ld_byte};
          3'd1:    wb_data = {{16{ld_half[15]}}, ld_half};
          3'd4:    wb_data = {24'd0, ld_byte};
          3'd5:    wb_data = {16'd0, ld_half};
          default: wb_data = ld_word;
        endcase
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= reset_pc_i;
      ld_rd_q  <= 5'd0;
      ld_f3_q  <= 3'd0;
      ld_off_q <= 3'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ld_rd_q  <= ld_rd_d;
      ld_f3_q  <= ld_f3_d;
      ld_off_q <= ld_off_d;
      if (wb_en && wb_rd != 5'd0) rf_q[wb_rd] <= wb_data;
    end
  end
endmodule

module srv_core_system #(
  parameter int AW_TCM = 12
) (
  input logic        clk,
  input logic        reset,
  input logic [31:0] reset_pc
);
  srv_core_system_if ibus ();
  srv_core_system_if dbus ();

  srv_core u_core (
    .clk        (clk),
    .reset      (reset),
    .reset_pc_i (reset_pc),
    .ibus       (ibus),
    .dbus       (dbus)
  );

  srv_tcm #(.AW(AW_TCM), .REGION(4'h8)) u_itcm (.clk(clk), .bus(ibus));
  srv_tcm #(.AW(AW_TCM), .REGION(4'h9)) u_dtcm (.clk(clk), .bus(dbus));
endmodule

// File: tb/tb_srv_core_system.sv
// Bench for srv_core_system: programs are placed in the ITCM by backdoor,
// run from reset, and registers / DTCM words are compared with expected
// values queued when each program is built.
module tb_srv_core_system;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] reset_pc = 32'h8000_0000;

  logic [63:0] exp_q[$];
  logic [63:0] exp;
  logic [31:0] prog[$];
  int          regs[$];
  int          n_vec = 0;
  int          n_err = 0;

  localparam logic [6:0] OPI = 7'b0010011, OPL = 7'b0000011, OPJR = 7'b1100111;
  localparam logic [6:0] OLUI = 7'b0110111, OAUI = 7'b0010111;

  srv_core_system #(.AW_TCM(12)) dut (.clk(clk), .reset(reset), .reset_pc(reset_pc));

  srv_core_system_if mon_bus ();
  assign mon_bus.addr  = dut.dbus.addr;
  assign mon_bus.re    = dut.dbus.re;
  assign mon_bus.be    = dut.dbus.be;
  assign mon_bus.wdata = dut.dbus.wdata;
  assign mon_bus.rdata = dut.dbus.rdata;

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                        input logic [31:0] f3, input logic [31:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [31:0] rd,
                                        input logic [6:0] op);
    return {imm20[19:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3,
                                        input logic [31:0] rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic put_instr(input logic [31:0] off, input logic [31:0] ins);
    if (off[2]) dut.u_itcm.mem[off[14:3]][63:32] = ins;
    else        dut.u_itcm.mem[off[14:3]][31:0]  = ins;
  endtask

  task automatic load_prog(input logic [31:0] base);
    for (int i = 0; i < 64; i++) dut.u_itcm.mem[i] = 64'd0;
    for (int i = 0; i < prog.size(); i++) put_instr(base + 32'(4 * i), prog[i]);
  endtask

  task automatic run_from(input logic [31:0] pc, input int cycles);
    @(negedge clk);
    reset    = 1'b1;
    reset_pc = pc;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic base_x2();
    prog.push_back(enc_u(32'h90001, 2, OLUI));
    prog.push_back(enc_i(-2048, 2, 0, 2, OPI));     // x2 = 0x9000_0800
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    prog.delete();
    prog.push_back(enc_i(5, 0, 0, 1, OPI));
    prog.push_back(enc_j(0, 0));
    load_prog(0);
    exp_q.push_back(64'h8000_0000);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd5);
    exp_q.push_back(64'h8000_0004);
    @(negedge clk);
    reset = 1'b1; reset_pc = 32'h8000_0000;
    repeat (3) @(negedge clk);
    exp = exp_q.pop_front(); n_vec++;
    if (dut.u_core.pc_q !== exp[31:0]) begin
      n_err++; $display("FAIL reset_pc got %h exp %h", dut.u_core.pc_q, exp[31:0]);
    end
    reset = 1'b0;
    @(negedge clk);
    exp = exp_q.pop_front(); n_vec++;
    if (dut.u_core.rf_q[1] !== exp[31:0]) begin
      n_err++; $display("FAIL reset_x1_early got %h exp %h", dut.u_core.rf_q[1], exp[31:0]);
    end
    @(negedge clk);
    exp = exp_q.pop_front(); n_vec++;
    if (dut.u_core.rf_q[1] !== exp[31:0]) begin
      n_err++; $display("FAIL reset_x1 got %h exp %h", dut.u_core.rf_q[1], exp[31:0]);
    end
    exp = exp_q.pop_front(); n_vec++;
    if (dut.u_core.pc_q !== exp[31:0]) begin
      n_err++; $display("FAIL reset_pc4 got %h exp %h", dut.u_core.pc_q, exp[31:0]);
    end
  endtask

  task automatic test_store_halt();
    logic [63:0] neighbour;
    neighbour = {$urandom, $urandom};
    dut.u_dtcm.mem[299] = neighbour;
    dut.u_dtcm.mem[300] = 64'hDEAD_BEEF_CAFE_F00D;
    prog.delete();
    base_x2();
    prog.push_back(enc_i(1, 0, 0, 3, OPI));
    prog.push_back(enc_s(32'h160, 3, 2, 2));         // sw x3,0x960 offset
    prog.push_back(enc_j(0, 0));
    load_prog(0);
    exp_q.push_back(64'hDEAD_BEEF_0000_0001);
    exp_q.push_back(neighbour);
    run_from(32'h8000_0000, 20);
    exp = exp_q.pop_front(); n_vec++;
    if (dut.u_dtcm.mem[300] !== exp) begin
      n_err++; $display("FAIL halt_word got %h exp %h", dut.u_dtcm.mem[300], exp);
    end
    exp = exp_q.pop_front(); n_vec++;
    if (dut.u_dtcm.mem[299] !== exp) begin
      n_err++; $display("FAIL halt_neighbour got %h exp %h", dut.u_dtcm.mem[299], exp);
    end
  endtask

  task automatic test_lanes();
    dut.u_dtcm.mem[301] = 64'h1122_3344_5566_7788;
    dut.u_dtcm.mem[302] = 64'h8001_7F7F_7F80_7F7F;
    prog.delete(); regs.delete();
    base_x2();
    prog.push_back(enc_u(32'hB, 4, OLUI));
    prog.push_back(enc_i(-1075, 4, 0, 4, OPI));      // x4 = 0xABCD
    prog.push_back(enc_s(32'h16E, 4, 2, 1));         // sh -> word 301 bytes 6..7
    prog.push_back(enc_i(32'h172, 2, 0, 5, OPL));    // lb
    prog.push_back(enc_i(32'h172, 2, 4, 6, OPL));    // lbu
    prog.push_back(enc_i(32'h176, 2, 1, 7, OPL));    // lh
    prog.push_back(enc_i(32'h177, 2, 5, 8, OPL));    // lhu, addr[0] ignored
    prog.push_back(enc_i(32'h177, 2, 2, 9, OPL));    // lw, addr[1:0] ignored
    prog.push_back(enc_i(-1, 0, 0, 11, OPI));
    prog.push_back(enc_i(0, 0, 2, 11, OPL));         // lw from non-DTCM
    prog.push_back(enc_s(32'h16B, 4, 2, 0));         // sb -> word 301 byte 3
    prog.push_back(enc_i(32'h16C, 2, 2, 10, OPL));   // lw upper half of 301
    prog.push_back(enc_j(0, 0));
    load_prog(0);
    regs = '{5, 6, 7, 8, 9, 10, 11};
    exp_q.push_back(64'hFFFF_FF80);
    exp_q.push_back(64'h0000_0080);
    exp_q.push_back(64'hFFFF_8001);
    exp_q.push_back(64'h0000_8001);
    exp_q.push_back(64'h8001_7F7F);
    exp_q.push_back(64'hABCD_3344);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'hABCD_3344_CD66_7788);
    run_from(32'h8000_0000, 60);
    for (int i = 0; i < regs.size(); i++) begin
      exp = exp_q.pop_front(); n_vec++;
      if (dut.u_core.rf_q[regs[i]] !== exp[31:0]) begin
        n_err++;
        $display("FAIL lanes_x%0d got %h exp %h", regs[i], dut.u_core.rf_q[regs[i]], exp[31:0]);
      end
    end
    exp = exp_q.pop_front(); n_vec++;
    if (dut.u_dtcm.mem[301] !== exp) begin
      n_err++; $display("FAIL lanes_mem301 got %h exp %h", dut.u_dtcm.mem[301], exp);
    end
  endtask

  task automatic test_control();
    prog.delete(); regs.delete();
    prog.push_back(enc_i(1, 0, 0, 5, OPI));          // 00
    prog.push_back(enc_i(-1, 0, 0, 6, OPI));         // 04
    prog.push_back(enc_u(32'h80000, 12, OLUI));      // 08
    prog.push_back(enc_i(0, 0, 0, 0, OPI));          // 0C
    prog.push_back(enc_j(8, 1));                     // 10 jal x1,+8
    prog.push_back(enc_i(99, 0, 0, 7, OPI));         // 14 skipped
    prog.push_back(enc_b(8, 6, 5, 6));               // 18 bltu taken
    prog.push_back(enc_i(99, 0, 0, 8, OPI));         // 1C skipped
    prog.push_back(enc_b(8, 6, 5, 4));               // 20 blt not taken
    prog.push_back(enc_i(7, 0, 0, 9, OPI));          // 24
    prog.push_back(enc_i(32'h35, 12, 0, 10, OPJR));  // 28 jalr -> 0x34
    prog.push_back(enc_i(99, 0, 0, 13, OPI));        // 2C skipped
    prog.push_back(enc_i(98, 0, 0, 13, OPI));        // 30 skipped
    prog.push_back(enc_j(0, 0));                     // 34
    load_prog(0);
    exp_q.push_back(64'h8000_0018);
    regs = '{1, 7, 8, 9, 10, 13};
    exp_q.push_back(64'h8000_0014);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd7);
    exp_q.push_back(64'h8000_002C);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'h8000_0034);
    run_from(32'h8000_0000, 10);
    exp = exp_q.pop_front(); n_vec++;
    if (dut.u_core.pc_q !== exp[31:0]) begin
      n_err++; $display("FAIL jal_target got %h exp %h", dut.u_core.pc_q, exp[31:0]);
    end
    repeat (40) @(negedge clk);
    for (int i = 0; i < regs.size(); i++) begin
      exp = exp_q.pop_front(); n_vec++;
      if (dut.u_core.rf_q[regs[i]] !== exp[31:0]) begin
        n_err++;
        $display("FAIL ctrl_x%0d got %h exp %h", regs[i], dut.u_core.rf_q[regs[i]], exp[31:0]);
      end
    end
    exp = exp_q.pop_front(); n_vec++;
    if (dut.u_core.pc_q !== exp[31:0]) begin
      n_err++; $display("FAIL ctrl_pc got %h exp %h", dut.u_core.pc_q, exp[31:0]);
    end
  endtask

  task automatic test_alu_edges();
    prog.delete(); regs.delete();
    prog.push_back(enc_u(32'h80000, 14, OLUI));      // 0
    prog.push_back(enc_i(33, 0, 0, 15, OPI));        // 1
    prog.push_back(enc_r(32'h20, 15, 14, 5, 16));    // 2 sra by 33
    prog.push_back(enc_i(-1, 0, 0, 18, OPI));        // 3
    prog.push_back(enc_r(0, 18, 0, 3, 17));          // 4 sltu
    prog.push_back(enc_i(5, 0, 0, 19, OPI));         // 5
    prog.push_back(enc_i(7, 0, 0, 0, OPI));          // 6 addi x0,x0,7
    prog.push_back(enc_r(0, 0, 0, 0, 19));           // 7 add x19,x0,x0
    prog.push_back(enc_i(32'h404, 14, 5, 20, OPI));  // 8 srai by 4
    prog.push_back(enc_r(0, 0, 18, 2, 21));          // 9 slt
    prog.push_back(enc_r(32'h20, 15, 0, 0, 22));     // 10 sub wraps
    prog.push_back(enc_u(32'h1, 23, OAUI));          // 11 auipc
    prog.push_back(32'h0010_0073);                   // 12 ebreak -> NOP
    prog.push_back(32'hFFFF_FFFF);                   // 13 illegal -> NOP
    prog.push_back(enc_i(3, 0, 0, 24, OPI));         // 14
    prog.push_back(enc_j(0, 0));                     // 15
    load_prog(0);
    regs = '{16, 17, 19, 20, 21, 22, 23, 24, 0};
    exp_q.push_back(64'hC000_0000);
    exp_q.push_back(64'd1);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'hF800_0000);
    exp_q.push_back(64'd1);
    exp_q.push_back(64'hFFFF_FFDF);
    exp_q.push_back(64'h8000_102C);
    exp_q.push_back(64'd3);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'h8000_003C);
    run_from(32'h8000_0000, 50);
    for (int i = 0; i < regs.size(); i++) begin
      exp = exp_q.pop_front(); n_vec++;
      if (dut.u_core.rf_q[regs[i]] !== exp[31:0]) begin
        n_err++;
        $display("FAIL alu_x%0d got %h exp %h", regs[i], dut.u_core.rf_q[regs[i]], exp[31:0]);
      end
    end
    exp = exp_q.pop_front(); n_vec++;
    if (dut.u_core.pc_q !== exp[31:0]) begin
      n_err++; $display("FAIL alu_pc got %h exp %h", dut.u_core.pc_q, exp[31:0]);
    end
  endtask

  task automatic test_random_alu();
    logic [31:0] a, b;
    for (int it = 0; it < 3; it++) begin
      a = $urandom;
      b = $urandom;
      if (it == 0) b[4:0] = 5'd31;
      prog.delete(); regs.delete();
      prog.push_back(enc_u((a + 32'h800) >> 12, 1, OLUI));
      prog.push_back(enc_i(a, 1, 0, 1, OPI));
      prog.push_back(enc_u((b + 32'h800) >> 12, 2, OLUI));
      prog.push_back(enc_i(b, 2, 0, 2, OPI));
      prog.push_back(enc_r(0, 2, 1, 0, 3));  exp_q.push_back({32'd0, a + b});
      prog.push_back(enc_r(32'h20, 2, 1, 0, 4)); exp_q.push_back({32'd0, a - b});
      prog.push_back(enc_r(0, 2, 1, 1, 5));  exp_q.push_back({32'd0, a << b[4:0]});
      prog.push_back(enc_r(0, 2, 1, 2, 6));  exp_q.push_back({63'd0, $signed(a) < $signed(b)});
      prog.push_back(enc_r(0, 2, 1, 3, 7));  exp_q.push_back({63'd0, a < b});
      prog.push_back(enc_r(0, 2, 1, 4, 8));  exp_q.push_back({32'd0, a ^ b});
      prog.push_back(enc_r(0, 2, 1, 5, 9));  exp_q.push_back({32'd0, a >> b[4:0]});
      prog.push_back(enc_r(32'h20, 2, 1, 5, 10));
      exp_q.push_back({32'd0, $unsigned($signed(a) >>> b[4:0])});
      prog.push_back(enc_r(0, 2, 1, 6, 11)); exp_q.push_back({32'd0, a | b});
      prog.push_back(enc_r(0, 2, 1, 7, 12)); exp_q.push_back({32'd0, a & b});
      prog.push_back(enc_j(0, 0));
      load_prog(0);
      regs = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
      run_from(32'h8000_0000, 40);
      for (int i = 0; i < regs.size(); i++) begin
        exp = exp_q.pop_front(); n_vec++;
        if (dut.u_core.rf_q[regs[i]] !== exp[31:0]) begin
          n_err++;
          $display("FAIL rand_alu a=%h b=%h x%0d got %h exp %h", a, b, regs[i],
                   dut.u_core.rf_q[regs[i]], exp[31:0]);
        end
      end
    end
  endtask

  task automatic test_fetch_outside();
    exp_q.push_back(64'h0000_0014);
    run_from(32'h0000_0000, 10);
    exp = exp_q.pop_front(); n_vec++;
    if (dut.u_core.pc_q !== exp[31:0]) begin
      n_err++; $display("FAIL fetch_outside_pc got %h exp %h", dut.u_core.pc_q, exp[31:0]);
    end
  endtask

  task automatic test_reset_mid_store();
    dut.u_dtcm.mem[300] = 64'h0123_4567_89AB_CDEF;
    prog.delete();
    base_x2();
    prog.push_back(enc_i(32'h55, 0, 0, 3, OPI));
    prog.push_back(enc_s(32'h160, 3, 2, 2));
    prog.push_back(enc_j(0, 0));
    load_prog(0);
    put_instr(32'h100, enc_j(0, 0));
    exp_q.push_back(64'd1);                          // core in EXEC on the sw
    exp_q.push_back(64'h0F);                         // sw lanes armed
    exp_q.push_back(64'h8000_0100);
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'h8000_0100);
    run_from(32'h8000_0000, 7);
    exp = exp_q.pop_front(); n_vec++;
    if (dut.u_core.state_q !== exp[1:0]) begin
      n_err++; $display("FAIL midstore_state got %0d exp %0d", dut.u_core.state_q, exp[1:0]);
    end
    exp = exp_q.pop_front(); n_vec++;
    if (mon_bus.be !== exp[7:0]) begin
      n_err++; $display("FAIL midstore_be got %h exp %h", mon_bus.be, exp[7:0]);
    end
    reset = 1'b1;
    reset_pc = 32'h8000_0100;
    repeat (2) @(negedge clk);
    exp = exp_q.pop_front(); n_vec++;
    if (dut.u_core.pc_q !== exp[31:0]) begin
      n_err++; $display("FAIL midstore_reset_pc got %h exp %h", dut.u_core.pc_q, exp[31:0]);
    end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    exp = exp_q.pop_front(); n_vec++;
    if (dut.u_dtcm.mem[300] !== exp) begin
      n_err++; $display("FAIL midstore_mem got %h exp %h", dut.u_dtcm.mem[300], exp);
    end
    exp = exp_q.pop_front(); n_vec++;
    if (dut.u_core.rf_q[3] !== exp[31:0]) begin
      n_err++; $display("FAIL midstore_x3 got %h exp %h", dut.u_core.rf_q[3], exp[31:0]);
    end
    exp = exp_q.pop_front(); n_vec++;
    if (dut.u_core.pc_q !== exp[31:0]) begin
      n_err++; $display("FAIL midstore_pc_after got %h exp %h", dut.u_core.pc_q, exp[31:0]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_store_halt();
    test_lanes();
    test_control();
    test_alu_edges();
    test_random_alu();
    test_fetch_outside();
    test_reset_mid_store();
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_leftover got %0d entries exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
